// File: rtl/gd_pkg.sv
// Shared types and constants for the gradient-descent sweep controller.
package gd_pkg;

    localparam int DATA_W    = 32;
    localparam int Y_W       = 64;
    localparam int FRAC_BITS = 8;

    // 1.0 in Q24.8
    localparam logic [DATA_W-1:0] ONE_Q = DATA_W'(1) << FRAC_BITS;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/gd_best_tracker.sv
// Keeps the best (lowest y) result seen during a sweep.
// clear_i arms the first-flag and zeroes the result.
// capture_i offers one (x, y, idx) result.
// Ties keep the earlier result because the compare is strict.
import gd_pkg::*;

module gd_best_tracker #(
    parameter int IDX_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              capture_i,
    input  logic [DATA_W-1:0] x_i,
    input  logic [Y_W-1:0]    y_i,
    input  logic [IDX_W-1:0]  idx_i,
    output logic [DATA_W-1:0] best_x_o,
    output logic [Y_W-1:0]    best_y_o,
    output logic [IDX_W-1:0]  best_idx_o
);

    logic              first_q,    first_d;
    logic [DATA_W-1:0] best_x_q,   best_x_d;
    logic [Y_W-1:0]    best_y_q,   best_y_d;
    logic [IDX_W-1:0]  best_idx_q, best_idx_d;

    // Next best: clear on sweep start, otherwise take a strictly smaller y (or the first result).
    always_comb begin
        first_d    = first_q;
        best_x_d   = best_x_q;
        best_y_d   = best_y_q;
        best_idx_d = best_idx_q;
        if (clear_i) begin
            first_d    = 1'b1;
            best_x_d   = '0;
            best_y_d   = '0;
            best_idx_d = '0;
        end else if (capture_i) begin
            first_d = 1'b0;
            if (first_q || ($signed(y_i) < $signed(best_y_q))) begin
                best_x_d   = x_i;
                best_y_d   = y_i;
                best_idx_d = idx_i;
            end
        end
    end

    // Best-result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            first_q    <= 1'b1;
            best_x_q   <= '0;
            best_y_q   <= '0;
            best_idx_q <= '0;
        end else begin
            first_q    <= first_d;
            best_x_q   <= best_x_d;
            best_y_q   <= best_y_d;
            best_idx_q <= best_idx_d;
        end
    end

    assign best_x_o   = best_x_q;
    assign best_y_o   = best_y_q;
    assign best_idx_o = best_idx_q;

endmodule

// File: rtl/gd_sweep_controller.sv
// Multi-start sequencer for the gradient-descent core.
// It steps x_init across NUM_STARTS points and runs the start_op/done_op handshake for each one.
// It reports the best (x_at_min, y_min) of the sweep.
import gd_pkg::*;

module gd_sweep_controller #(
    parameter int                NUM_STARTS     = 10,
    parameter logic [DATA_W-1:0] X_START        = 32'h0000_0000,
    parameter logic [DATA_W-1:0] X_STEP         = ONE_Q,
    parameter int                TIMEOUT_CYCLES = 4096,
    parameter int                IDX_W          = $clog2(NUM_STARTS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    output logic [DATA_W-1:0] best_x,
    output logic [Y_W-1:0]    best_y,
    output logic [IDX_W-1:0]  best_idx,
    output logic              gd_start_op,
    output logic [DATA_W-1:0] gd_x_init,
    input  logic [DATA_W-1:0] gd_x_at_min,
    input  logic [Y_W-1:0]    gd_y_min,
    input  logic              gd_done_op
);

    generate
        if (NUM_STARTS < 1) begin : g_bad_num_starts
            $error("gd_sweep_controller: NUM_STARTS must be >= 1");
        end
    endgenerate

    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // The run aborts on the edge that ends its TIMEOUT_CYCLES-th RUN cycle.
    localparam logic [TMR_W-1:0] TMR_LAST =
        TMR_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST =
        IDX_W'((NUM_STARTS > 0) ? NUM_STARTS - 1 : 0);

    state_t            state_q,    state_d;
    logic [IDX_W-1:0]  idx_q,      idx_d;
    logic [DATA_W-1:0] x_init_q,   x_init_d;
    logic              start_op_q, start_op_d;
    logic [TMR_W-1:0]  timer_q,    timer_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;
    logic              terr_q,     terr_d;
    logic              trk_clear;
    logic              trk_capture;

    // Sweep FSM next-state and registered-output decode
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        x_init_d    = x_init_q;
        start_op_d  = start_op_q;
        timer_d     = timer_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        terr_d      = terr_q;
        trk_clear   = 1'b0;
        trk_capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    x_init_d   = X_START;
                    idx_d      = '0;
                    start_op_d = 1'b1;
                    busy_d     = 1'b1;
                    terr_d     = 1'b0;
                    timer_d    = '0;
                    trk_clear  = 1'b1;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                // A done_op that is still high on entry counts as completion.
                if (gd_done_op) begin
                    trk_capture = 1'b1;
                    start_op_d  = 1'b0;
                    state_d     = ST_DRAIN;
                end else if ((TIMEOUT_CYCLES != 0) && (timer_q == TMR_LAST)) begin
                    terr_d     = 1'b1;
                    start_op_d = 1'b0;
                    state_d    = ST_FINISH;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                // Do not start the next run until the core has dropped done_op.
                if (!gd_done_op) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_FINISH;
                    end else begin
                        idx_d      = idx_q + 1'b1;
                        x_init_d   = x_init_q + X_STEP;
                        start_op_d = 1'b1;
                        timer_d    = '0;
                        state_d    = ST_RUN;
                    end
                end
            end
            ST_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            x_init_q   <= X_START;
            start_op_q <= 1'b0;
            timer_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            terr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            x_init_q   <= x_init_d;
            start_op_q <= start_op_d;
            timer_q    <= timer_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            terr_q     <= terr_d;
        end
    end

    gd_best_tracker #(
        .IDX_W (IDX_W)
    ) u_best (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (trk_clear),
        .capture_i  (trk_capture),
        .x_i        (gd_x_at_min),
        .y_i        (gd_y_min),
        .idx_i      (idx_q),
        .best_x_o   (best_x),
        .best_y_o   (best_y),
        .best_idx_o (best_idx)
    );

    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = terr_q;
    assign gd_start_op = start_op_q;
    assign gd_x_init   = x_init_q;

endmodule

// File: tb/tb_gd_sweep_controller.sv
// Bench for gd_sweep_controller.
// Instance 0 uses the default parameters.
// Instance 1 uses NUM_STARTS=3, X_START=0x7FFFFF00 and TIMEOUT_CYCLES=16.
// A behavioural core stub answers each run.
// Expected x_init values and sweep results go into per-instance queues.
// A negedge monitor pops those queues and compares them against the DUT.
`timescale 1ns/1ps
module tb_gd_sweep_controller;

    typedef struct packed {
        logic        terr;
        logic [3:0]  idx;
        logic [31:0] x;
        logic [63:0] y;
    } res_t;

    localparam logic [31:0] XS0 = 32'h0000_0000;
    localparam logic [31:0] XS1 = 32'h7FFF_FF00;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic        start_a [2];
    logic        busy_a  [2];
    logic        done_a  [2];
    logic        terr_a  [2];
    logic        sop_a   [2];
    logic        dop_a   [2];
    logic [31:0] bx_a    [2];
    logic [31:0] xin_a   [2];
    logic [63:0] by_a    [2];
    logic [3:0]  bi_a    [2];

    // Stub configuration: answer delay, done_op hold after start_op falls, run that never answers.
    int          delay_c [2];
    int          hold_c  [2];
    int          hang_c  [2];
    logic [63:0] ytab    [10];

    logic [31:0] exp_x_q [2][$];
    res_t        exp_r_q [2][$];

    logic sop_prev [2];
    int   hi_cnt   [2];
    int   last_hi  [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int          NS = (gi == 0) ? 10 : 3;
        localparam logic [31:0] XS = (gi == 0) ? XS0 : XS1;
        localparam int          TO = (gi == 0) ? 4096 : 16;
        localparam int          IW = $clog2(NS + 1);

        logic          busy, done, terr, sop, dop_q;
        logic [31:0]   bx, xin, xm_q;
        logic [63:0]   by, ym_q;
        logic [IW-1:0] bi;
        int            cnt, lowc, run;

        gd_sweep_controller #(
            .NUM_STARTS     (NS),
            .X_START        (XS),
            .X_STEP         (32'h100),
            .TIMEOUT_CYCLES (TO)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .start       (start_a[gi]),
            .busy        (busy),
            .done        (done),
            .timeout_err (terr),
            .best_x      (bx),
            .best_y      (by),
            .best_idx    (bi),
            .gd_start_op (sop),
            .gd_x_init   (xin),
            .gd_x_at_min (xm_q),
            .gd_y_min    (ym_q),
            .gd_done_op  (dop_q)
        );

        assign run = int'((xin - XS) >> 8);

        // Core stub: x_at_min = run*256, y_min = ytab[run].
        always @(posedge clk) begin
            if (rst) begin
                dop_q <= 1'b0;
                xm_q  <= '0;
                ym_q  <= '0;
                cnt   <= 0;
                lowc  <= 0;
            end else if (sop) begin
                lowc <= 0;
                if (!dop_q && (run != hang_c[gi])) begin
                    if (cnt >= delay_c[gi]) begin
                        dop_q <= 1'b1;
                        xm_q  <= 32'(run) << 8;
                        ym_q  <= (run < 10) ? ytab[run] : 64'd0;
                    end else begin
                        cnt <= cnt + 1;
                    end
                end
            end else begin
                cnt <= 0;
                if (dop_q) begin
                    if (lowc >= hold_c[gi]) dop_q <= 1'b0;
                    else lowc <= lowc + 1;
                end
            end
        end

        assign busy_a[gi] = busy;
        assign done_a[gi] = done;
        assign terr_a[gi] = terr;
        assign sop_a[gi]  = sop;
        assign dop_a[gi]  = dop_q;
        assign bx_a[gi]   = bx;
        assign by_a[gi]   = by;
        assign xin_a[gi]  = xin;
        assign bi_a[gi]   = 4'(bi);
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic fail_now(string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Monitor: one x_init check per start_op rise, one result check per done pulse.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (sop_a[k] && !sop_prev[k]) begin
                hi_cnt[k] = 0;
                if (exp_x_q[k].size() == 0) begin
                    fail_now($sformatf("inst%0d unexpected run x_init=%h", k, xin_a[k]));
                end else begin
                    logic [31:0] ex;
                    ex = exp_x_q[k].pop_front();
                    chk($sformatf("inst%0d run x_init", k), 64'(xin_a[k]), 64'(ex));
                    chk($sformatf("inst%0d done_op low at run start", k), 64'(dop_a[k]), 64'd0);
                end
            end
            if (sop_a[k]) hi_cnt[k]++;
            else if (sop_prev[k]) last_hi[k] = hi_cnt[k];
            if (done_a[k]) begin
                if (exp_r_q[k].size() == 0) begin
                    fail_now($sformatf("inst%0d unexpected done pulse", k));
                end else begin
                    res_t r;
                    r = exp_r_q[k].pop_front();
                    chk($sformatf("inst%0d best_idx", k), 64'(bi_a[k]), 64'(r.idx));
                    chk($sformatf("inst%0d best_x", k), 64'(bx_a[k]), 64'(r.x));
                    chk($sformatf("inst%0d best_y", k), by_a[k], r.y);
                    chk($sformatf("inst%0d timeout_err", k), 64'(terr_a[k]), 64'(r.terr));
                    chk($sformatf("inst%0d busy low with done", k), 64'(busy_a[k]), 64'd0);
                    chk($sformatf("inst%0d runs left at done", k), 64'(exp_x_q[k].size()), 64'd0);
                end
            end
            sop_prev[k] = sop_a[k];
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start(int k);
        @(negedge clk);
        start_a[k] = 1'b1;
        @(negedge clk);
        start_a[k] = 1'b0;
    endtask

    task automatic wait_idle(int k);
        int n;
        n = 0;
        while (busy_a[k] && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (busy_a[k]) fail_now($sformatf("inst%0d sweep did not finish in 3000 cycles", k));
    endtask

    task automatic push_runs(int k, logic [31:0] xs, int nruns);
        for (int i = 0; i < nruns; i++) exp_x_q[k].push_back(xs + 32'(i) * 32'h100);
    endtask

    task automatic sweep(int k, logic [31:0] xs, int nruns, res_t r);
        push_runs(k, xs, nruns);
        exp_r_q[k].push_back(r);
        pulse_start(k);
        chk($sformatf("inst%0d busy after start", k), 64'(busy_a[k]), 64'd1);
        wait_idle(k);
        cyc(3);
        chk($sformatf("inst%0d result consumed", k), 64'(exp_r_q[k].size()), 64'd0);
    endtask

    task automatic chk_reset(int k, logic [31:0] xs);
        chk($sformatf("inst%0d rst busy", k), 64'(busy_a[k]), 64'd0);
        chk($sformatf("inst%0d rst done", k), 64'(done_a[k]), 64'd0);
        chk($sformatf("inst%0d rst timeout_err", k), 64'(terr_a[k]), 64'd0);
        chk($sformatf("inst%0d rst start_op", k), 64'(sop_a[k]), 64'd0);
        chk($sformatf("inst%0d rst best_x", k), 64'(bx_a[k]), 64'd0);
        chk($sformatf("inst%0d rst best_y", k), by_a[k], 64'd0);
        chk($sformatf("inst%0d rst best_idx", k), 64'(bi_a[k]), 64'd0);
        chk($sformatf("inst%0d rst x_init", k), 64'(xin_a[k]), 64'(xs));
    endtask

    task automatic set_parabola();
        int base [10];
        base = '{9, 4, 1, 0, 1, 4, 9, 16, 25, 36};
        for (int i = 0; i < 10; i++) ytab[i] = 64'(base[i]) * 64'd256;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int k = 0; k < 2; k++) begin
            start_a[k]  = 1'b0;
            delay_c[k]  = 3;
            hold_c[k]   = 0;
            hang_c[k]   = -1;
            sop_prev[k] = 1'b0;
            hi_cnt[k]   = 0;
            last_hi[k]  = 0;
        end
        delay_c[1] = 2;
        set_parabola();

        // Reset state
        cyc(3);
        chk_reset(0, XS0);
        chk_reset(1, XS1);
        rst = 1'b0;
        cyc(2);

        // 1: parabola, minimum at run 3
        sweep(0, XS0, 10, '{terr: 1'b0, idx: 4'd3, x: 32'h300, y: 64'd0});

        // 2a: all equal, tie keeps run 0
        for (int i = 0; i < 10; i++) ytab[i] = 64'h500;
        sweep(0, XS0, 10, '{terr: 1'b0, idx: 4'd0, x: 32'h0, y: 64'h500});

        // 2b: negative y at run 7 wins
        ytab[7] = 64'hFFFF_FFFF_FFFF_FF00;
        sweep(0, XS0, 10, '{terr: 1'b0, idx: 4'd7, x: 32'h700, y: 64'hFFFF_FFFF_FFFF_FF00});

        // 6: done_op held 5 cycles after start_op falls
        set_parabola();
        hold_c[0] = 5;
        sweep(0, XS0, 10, '{terr: 1'b0, idx: 4'd3, x: 32'h300, y: 64'd0});
        hold_c[0] = 0;

        // 5a: start pulsed while running is ignored
        push_runs(0, XS0, 10);
        exp_r_q[0].push_back('{terr: 1'b0, idx: 4'd3, x: 32'h300, y: 64'd0});
        pulse_start(0);
        cyc(2);
        pulse_start(0);
        wait_idle(0);
        cyc(3);
        chk("inst0 result consumed after ignored start", 64'(exp_r_q[0].size()), 64'd0);

        // 5b: reset while in DRAIN, then a clean sweep
        ytab[7] = 64'hFFFF_FFFF_FFFF_FF00;
        push_runs(0, XS0, 10);
        pulse_start(0);
        n = 0;
        while (!(busy_a[0] && !sop_a[0] && dop_a[0]) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail_now("inst0 never reached DRAIN");
        rst = 1'b1;
        @(negedge clk);
        chk_reset(0, XS0);
        rst = 1'b0;
        exp_x_q[0].delete();
        cyc(2);
        sweep(0, XS0, 10, '{terr: 1'b0, idx: 4'd7, x: 32'h700, y: 64'hFFFF_FFFF_FFFF_FF00});

        // 3: x_init wraps past 0x7FFFFFFF
        ytab[0] = 64'h500;
        ytab[1] = 64'h300;
        ytab[2] = 64'h700;
        sweep(1, XS1, 3, '{terr: 1'b0, idx: 4'd1, x: 32'h100, y: 64'h300});

        // 4: run 2 never answers, aborted after 16 RUN cycles
        hang_c[1] = 2;
        sweep(1, XS1, 3, '{terr: 1'b1, idx: 4'd1, x: 32'h100, y: 64'h300});
        chk("inst1 start_op high cycles before timeout", 64'(last_hi[1]), 64'd16);
        cyc(5);
        chk("inst1 timeout_err sticky", 64'(terr_a[1]), 64'd1);
        hang_c[1] = -1;
        sweep(1, XS1, 3, '{terr: 1'b0, idx: 4'd1, x: 32'h100, y: 64'h300});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
